spi_shift_master: RTL
=====================

Name: spi_shift_master

Overview:
- SPI initiator that issues one shift-processor transaction per host request.
- Each transaction sends a 4-bit opcode, operand A and operand B MSB-first on mosi, then reads a REG_WIDTH-bit result MSB-first from miso.
- Sits between a local host (testbench driver or control FSM) and the slave-side shift processor.
- Opcodes: SHL 4'b0110, SHR 4'b0111, SAR 4'b1000. The opcode is passed through without checking.

Parameters:
REG_WIDTH, 32, operand/result width in bits
SCLK_DIV, 4, system clocks per SPI bit period; legal range ≥ 2
TURNAROUND, 2, sclk-idle clocks between last B bit and first result bit
GAP_CYCLES, 2, clocks nss stays high after a frame before a new start is accepted

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a transaction; sampled only in IDLE
abort  input  1  terminate current frame
opcode  input  4  operation code, latched on accept
operand_a  input  REG_WIDTH  latched on accept
operand_b  input  REG_WIDTH  latched on accept
busy  output  1  high from accept edge until return to IDLE
done  output  1  one-cycle pulse; result valid that cycle and held after
aborted  output  1  one-cycle pulse on abort
result  output  REG_WIDTH  last received result
sclk  output  1  SPI clock
nss  output  1  SPI select, active low
mosi  output  1  SPI data out
miso  input  1  SPI data in

Behaviour:
- Reset values: nss=1, sclk=0, mosi=0, busy=0, done=0, aborted=0, result=0. Internal counters clear to 0.
- Reset mid-frame has the same effect: nss rises asynchronously and no done pulse is issued.
- States: IDLE, SETUP, SEND, TURN, RECV, DONE, GAP.
- Transitions:
  - IDLE: start=1 latches opcode/operand_a/operand_b into a (4+2*REG_WIDTH)-bit shift register as {opcode,A,B}, sets busy=1 and moves to SETUP. start is ignored in every other state.
  - SETUP: nss=0, sclk=0 for SCLK_DIV clocks → SEND.
  - SEND: 4+2*REG_WIDTH bit periods → TURN.
  - TURN: nss=0, sclk=0, mosi=0 for TURNAROUND clocks → RECV.
  - RECV: REG_WIDTH bit periods → DONE.
  - DONE: 1 clock; nss=1, done=1, result updated → GAP.
  - GAP: nss=1 for GAP_CYCLES clocks → IDLE, busy=0.
- Bit period (SEND and RECV):
  - A phase counter runs 0..SCLK_DIV-1.
  - mosi shows the current MSB from phase 0 and is stable for the whole period.
  - sclk=1 only when phase==SCLK_DIV-1, i.e. exactly one clock high per bit. The slave samples on sclk level, so a wider pulse is forbidden.
  - On the phase==SCLK_DIV-1 edge, SEND shifts the tx register left.
  - On the same edge, RECV shifts miso into the rx register LSB.
  - mosi=0 in RECV.
- Latency: done is high in the cycle following edge E0 + SCLK_DIV*(5+3*REG_WIDTH) + TURNAROUND, where E0 is the accept edge. Defaults give 406. A following start can be accepted no earlier than GAP_CYCLES+1 clocks after done.
- Bit count: 4+2*REG_WIDTH sclk pulses out and REG_WIDTH pulses in. Total is exactly 100 pulses per frame at default.
- abort:
  - In SETUP..RECV, the next edge forces nss=1, sclk=0, mosi=0 and aborted=1 for one cycle, then enters GAP.
  - result is unchanged and no done pulse is issued.
  - abort in IDLE, DONE or GAP is ignored.
  - abort and start together in IDLE: start wins; abort is ignored.
- The result register holds its value until the next successful DONE.

Test Plan:
- SHL: opcode=0110, A=0x00000001, B=0x00000004; slave model returns 0x00000010.
  - result=0x00000010.
  - done pulse at E0+406.
  - First four mosi bits sampled at sclk high are 0,1,1,0.
  - Exactly 100 sclk pulses seen, each one clock wide.
- SAR: opcode=1000, A=0x80000000, B=0x0000001F; slave returns 0xFFFFFFFF.
  - result=0xFFFFFFFF.
  - mosi bits 5..36 equal A MSB-first.
  - mosi bits 37..68 equal B MSB-first.
- Busy lockout: second start pulse with different operands at E0+50 is ignored. The frame carries the first operands, and only one done pulse occurs.
- Abort: abort at the 10th sclk pulse of operand A.
  - nss=1 next cycle; aborted pulses once; done stays 0.
  - result keeps its prior value (0xFFFFFFFF).
  - busy drops GAP_CYCLES+1 clocks later.
- Reset: async reset asserted during RECV. nss=1 and sclk=0 immediately, busy=0, result=0. A fresh start afterward completes normally.
- Back-to-back: start held high continuously, two frames run. nss stays high ≥ GAP_CYCLES+1 clocks between frames, with a done pulse for each.

Source files
------------

// File: rtl/spi_shift_master.sv
// SPI initiator for the shift processor: sends {opcode, A, B} MSB-first on mosi,
// then reads a REG_WIDTH-bit result MSB-first from miso.
//
// state   | meaning
// IDLE    | nss high, waiting for start
// SETUP   | nss low, sclk low for SCLK_DIV clocks before the first bit
// SEND    | shifting opcode, A and B out on mosi
// TURN    | nss low, sclk/mosi low for TURNAROUND clocks
// RECV    | shifting the result in from miso
// DONE    | one-cycle done pulse, result valid
// GAP     | nss high for GAP_CYCLES clocks (one extra after abort)
module spi_shift_master #(
  parameter int REG_WIDTH  = 32,
  parameter int SCLK_DIV   = 4,
  parameter int TURNAROUND = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           opcode,
  input  logic [REG_WIDTH-1:0] operand_a,
  input  logic [REG_WIDTH-1:0] operand_b,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [REG_WIDTH-1:0] result,
  output logic                 sclk,
  output logic                 nss,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int FRAME_BITS = 4 + 2 * REG_WIDTH;
  localparam int PH_W       = $clog2(SCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int TMR_A      = (SCLK_DIV > TURNAROUND) ? SCLK_DIV : TURNAROUND;
  localparam int TMR_MAX    = (TMR_A > GAP_CYCLES + 1) ? TMR_A : GAP_CYCLES + 1;
  localparam int TMR_W      = $clog2(TMR_MAX);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_SEND  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_RECV  = BIT_W'(REG_WIDTH - 1);
  localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_TURN  = TMR_W'(TURNAROUND - 1);
  localparam logic [TMR_W-1:0] TMR_GAP   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ABORT = TMR_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SEND, S_TURN, S_RECV, S_DONE, S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase;
  logic [BIT_W-1:0]        bit_cnt;
  logic [TMR_W-1:0]        tmr;
  logic [FRAME_BITS-1:0]   tx_sr;
  logic [REG_WIDTH-1:0]    rx_sr;
  logic [REG_WIDTH-1:0]    result_q;
  logic                    aborted_q;

  logic last_phase, bit_tc, tmr_tc, in_frame, abort_hit;

  assign last_phase = (phase == PH_LAST);
  assign bit_tc     = (bit_cnt == '0);
  assign tmr_tc     = (tmr == '0);
  assign in_frame   = state_q inside {S_SETUP, S_SEND, S_TURN, S_RECV};
  assign abort_hit  = abort && in_frame;

  // Outputs decode straight from registered state so reset forces nss high at once.
  assign nss     = !in_frame;
  assign sclk    = (state_q == S_SEND || state_q == S_RECV) && last_phase;
  assign mosi    = (state_q == S_SEND) ? tx_sr[FRAME_BITS-1] : 1'b0;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign aborted = aborted_q;
  assign result  = result_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: if (tmr_tc) state_d = S_SEND;
      S_SEND:  if (last_phase && bit_tc) state_d = S_TURN;
      S_TURN:  if (tmr_tc) state_d = S_RECV;
      S_RECV:  if (last_phase && bit_tc) state_d = S_DONE;
      S_DONE:  state_d = S_GAP;
      S_GAP:   if (tmr_tc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_GAP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase     <= '0;
      bit_cnt   <= '0;
      tmr       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      result_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
      // Abort gets one extra gap clock to cover the aborted-pulse cycle.
      if (abort_hit) begin
        tmr <= TMR_ABORT;
      end else begin
        case (state_q)
          S_IDLE: if (start) begin
            tx_sr <= {opcode, operand_a, operand_b};
            tmr   <= TMR_SETUP;
          end
          S_SETUP, S_TURN: begin
            if (!tmr_tc) begin
              tmr <= tmr - TMR_W'(1);
            end else begin
              phase   <= '0;
              bit_cnt <= (state_q == S_SETUP) ? BIT_SEND : BIT_RECV;
            end
          end
          S_SEND: begin
            phase <= last_phase ? '0 : phase + PH_W'(1);
            if (last_phase) begin
              tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
              bit_cnt <= bit_cnt - BIT_W'(1);
              if (bit_tc) tmr <= TMR_TURN;
            end
          end
          S_RECV: begin
            phase <= last_phase ? '0 : phase + PH_W'(1);
            if (last_phase) begin
              rx_sr   <= {rx_sr[REG_WIDTH-2:0], miso};
              bit_cnt <= bit_cnt - BIT_W'(1);
              if (bit_tc) result_q <= {rx_sr[REG_WIDTH-2:0], miso};
            end
          end
          S_DONE:  tmr <= TMR_GAP;
          S_GAP:   if (!tmr_tc) tmr <= tmr - TMR_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule
